// File: rtl/mont_exp_ctrl_pkg.sv
// Shared encodings for the modular-exponentiation sequencer.
//   op_e    : which Montgomery product is being issued to the multiplier
//   state_e : sequencer FSM state (visible as mont_exp_ctrl.state_q)
package mont_exp_ctrl_pkg;

  // Product kinds, in the order a run first meets them.
  typedef enum logic [1:0] {
    OP_TOMONT = 2'd0,  // x * R^2 -> x in Montgomery domain
    OP_SQ     = 2'd1,  // acc * acc
    OP_MUL    = 2'd2,  // acc * xm
    OP_FROM   = 2'd3   // acc * 1 -> back to normal domain
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mont_exp_ctrl.sv
// Modular-exponentiation sequencer: result = x^e mod M using left-to-right
// square-and-multiply over an external Montgomery multiplier.
//
// Ports:
//   clk, resetn            clock (rising edge), async active-low reset
//   start                  one-cycle request, sampled only in IDLE
//   in_x, in_e, in_m       base (x < M), exponent, odd modulus M > 1
//   in_r, in_r2            R mod M and R^2 mod M, R = 2^WIDTH
//   mm_start/mm_a/mm_b/mm_m  request to the multiplier
//   mm_result/mm_done      multiplier response
//   result, done, busy     final value, completion pulse, run in progress
//
// Multiplier handshake: this block is the initiator. mm_start is high for
// exactly the ISSUE cycle; mm_a/mm_b/mm_m are stable from that cycle until
// the cycle in which mm_done=1. mm_result is only sampled while in WAIT with
// mm_done=1; mm_done seen in any other state is ignored. No fixed latency is
// assumed.
module mont_exp_ctrl
  import mont_exp_ctrl_pkg::*;
#(
  parameter int WIDTH   = 1024,
  parameter int E_WIDTH = 1024
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [WIDTH-1:0]   in_r,
  input  logic [WIDTH-1:0]   in_r2,
  output logic               mm_start,
  output logic [WIDTH-1:0]   mm_a,
  output logic [WIDTH-1:0]   mm_b,
  output logic [WIDTH-1:0]   mm_m,
  input  logic [WIDTH-1:0]   mm_result,
  input  logic               mm_done,
  output logic [WIDTH-1:0]   result,
  output logic               done,
  output logic               busy
);

  localparam int IDX_W = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

  state_e               state_q;
  op_e                  op_q, op_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [E_WIDTH-1:0]   e_q;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     xm_q, xm_d;
  logic [WIDTH-1:0]     opa_d, opb_d;
  logic                 step;

  logic                 mm_start_q, done_q, busy_q;
  logic [WIDTH-1:0]     mm_a_q, mm_b_q, mm_m_q, result_q;

  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign mm_m     = mm_m_q;
  assign result   = result_q;
  assign done     = done_q;
  assign busy     = busy_q;

  // What a completed product turns into, and the operands of the product
  // that follows it. Only used when mm_done arrives in WAIT.
  always_comb begin
    acc_d = acc_q;
    xm_d  = xm_q;
    op_d  = op_q;
    idx_d = idx_q;
    step  = 1'b0;
    unique case (op_q)
      OP_TOMONT: begin
        xm_d = mm_result;
        op_d = OP_SQ;
      end
      OP_SQ: begin
        acc_d = mm_result;
        if (e_q[idx_q]) op_d = OP_MUL;
        else            step = 1'b1;
      end
      OP_MUL: begin
        acc_d = mm_result;
        step  = 1'b1;
      end
      default: ;
    endcase
    if (step) begin
      if (idx_q == '0) begin
        op_d = OP_FROM;
      end else begin
        idx_d = idx_q - IDX_W'(1);
        op_d  = OP_SQ;
      end
    end

    // TOMONT is only ever issued straight from IDLE, so it needs no case here.
    unique case (op_d)
      OP_SQ:   begin opa_d = acc_d; opb_d = acc_d;       end
      OP_MUL:  begin opa_d = acc_d; opb_d = xm_d;        end
      default: begin opa_d = acc_d; opb_d = WIDTH'(1);   end
    endcase
  end

  // Operands and mm_start are loaded on the edge that enters ISSUE, so the
  // pulse and the operands appear together in the ISSUE cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_TOMONT;
      idx_q      <= '0;
      e_q        <= '0;
      acc_q      <= '0;
      xm_q       <= '0;
      mm_start_q <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      mm_m_q     <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            e_q        <= in_e;
            acc_q      <= in_r;      // 1 in Montgomery domain
            xm_q       <= '0;
            idx_q      <= IDX_W'(E_WIDTH - 1);
            op_q       <= OP_TOMONT;
            mm_m_q     <= in_m;
            mm_a_q     <= in_x;
            mm_b_q     <= in_r2;
            mm_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mm_start_q <= 1'b0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mm_done) begin
            if (op_q == OP_FROM) begin
              result_q <= mm_result;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              acc_q      <= acc_d;
              xm_q       <= xm_d;
              op_q       <= op_d;
              idx_q      <= idx_d;
              mm_a_q     <= opa_d;
              mm_b_q     <= opb_d;
              mm_start_q <= 1'b1;
              state_q    <= ST_ISSUE;
            end
          end
        end
        default: begin  // ST_DONE
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl with WIDTH=8, E_WIDTH=4, M=13, R mod M=9, R^2 mod M=3.
// A behavioural multiplier returns a*b*R^-1 mod M (R^-1 mod 13 = 3) after a
// programmable latency.
module tb_mont_exp_ctrl;

  localparam int W  = 8;
  localparam int EW = 4;

  logic          clk    = 1'b0;
  logic          resetn = 1'b0;
  logic          start  = 1'b0;
  logic [W-1:0]  in_x   = '0;
  logic [EW-1:0] in_e   = '0;
  logic [W-1:0]  in_m   = '0;
  logic [W-1:0]  in_r   = '0;
  logic [W-1:0]  in_r2  = '0;
  logic          mm_start, done, busy;
  logic [W-1:0]  mm_a, mm_b, mm_m, result;
  logic [W-1:0]  mm_result = '0;
  logic          mm_done   = 1'b0;

  int n_tests  = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int lat      = 1;
  bit spur     = 1'b0;

  logic [W-1:0]   exp_q[$];     // expected final results
  logic [2*W-1:0] exp_op_q[$];  // expected {a, b} per issued product

  mont_exp_ctrl #(.WIDTH(W), .E_WIDTH(EW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
    .mm_result(mm_result), .mm_done(mm_done),
    .result(result), .done(done), .busy(busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    return W'((ia * ib * 3) % 13);
  endfunction

  function automatic logic [W-1:0] pow_mod(input int x, input int e);
    int r;
    r = 1 % 13;
    for (int i = 0; i < e; i++) r = (r * x) % 13;
    return W'(r);
  endfunction

  // ---------------- multiplier model ----------------
  initial begin : mult_model
    logic [W-1:0]   pa, pb;
    logic [2*W-1:0] ep;
    bit             aborted;
    forever begin
      @(negedge clk);
      mm_done = 1'b0;
      if (resetn && mm_start) begin
        n_starts++;
        pa = mm_a;
        pb = mm_b;
        check("mm_m", mm_m, 13);
        if (exp_op_q.size() > 0) begin
          ep = exp_op_q.pop_front();
          check("op_a", pa, ep[2*W-1:W]);
          check("op_b", pb, ep[W-1:0]);
        end else begin
          check("unexpected_op", 1, 0);
        end
        if (spur) begin
          // Pulse during ISSUE; must be ignored by the sequencer.
          mm_done   = 1'b1;
          mm_result = 8'hAA;
        end
        aborted = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          mm_done = 1'b0;
          if (!resetn) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          check("op_a_stable", mm_a, pa);
          check("op_b_stable", mm_b, pb);
          mm_result = mont(pa, pb);
          mm_done   = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic kick(input logic [W-1:0] x, input logic [EW-1:0] e, input int l, input bit sp);
    logic [W-1:0] xm, acc;
    lat  = l;
    spur = sp;
    exp_op_q.push_back({x, 8'd3});
    xm  = mont(x, 8'd3);
    acc = 8'd9;
    for (int i = EW - 1; i >= 0; i--) begin
      exp_op_q.push_back({acc, acc});
      acc = mont(acc, acc);
      if (e[i]) begin
        exp_op_q.push_back({acc, xm});
        acc = mont(acc, xm);
      end
    end
    exp_op_q.push_back({acc, 8'd1});
    exp_q.push_back(pow_mod(int'(x), int'(e)));
    @(negedge clk);
    in_x  = x;
    in_e  = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic finish_run(input string tag, input int base, input int exp_cnt);
    bit got;
    logic [W-1:0] ev;
    got = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, got, 1);
    ev = exp_q.pop_front();
    if (got) begin
      check({tag, "_result"}, result, ev);
      check({tag, "_busy_at_done"}, busy, 1);
      check({tag, "_mm_starts"}, n_starts - base, exp_cnt);
      check({tag, "_ops_left"}, exp_op_q.size(), 0);
      @(negedge clk);
      check({tag, "_done_width"}, done, 0);
      check({tag, "_busy_after"}, busy, 0);
      check({tag, "_result_hold"}, result, ev);
    end
    exp_op_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mm_start"}, mm_start, 0);
    check({tag, "_mm_a"},     mm_a, 0);
    check({tag, "_mm_b"},     mm_b, 0);
    check({tag, "_mm_m"},     mm_m, 0);
    check({tag, "_result"},   result, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_busy"},     busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int base;
    int guard;
    resetn = 1'b0;
    in_m   = 8'd13;
    in_r   = 8'd9;
    in_r2  = 8'd3;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;

    // x=2, e=5, latency 3 -> 6, 8 products
    base = n_starts;
    kick(8'd2, 4'd5, 3, 1'b0);
    finish_run("x2e5", base, 8);

    // x=2, e=15, latency 1 -> 8, 10 products
    base = n_starts;
    kick(8'd2, 4'd15, 1, 1'b0);
    finish_run("x2e15", base, 10);

    // x=3, e=12 -> 1
    base = n_starts;
    kick(8'd3, 4'd12, 2, 1'b0);
    finish_run("x3e12", base, 8);

    // x=7, e=0 -> 1, 6 products
    base = n_starts;
    kick(8'd7, 4'd0, 1, 1'b0);
    finish_run("x7e0", base, 6);

    // latency 37, spurious mm_done in ISSUE, start pulsed again mid-run
    base = n_starts;
    kick(8'd2, 4'd5, 37, 1'b1);
    guard = 0;
    while ((n_starts - base) < 3 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("poke_reach_op3", guard < 2000, 1);
    in_x  = 8'd5;
    in_e  = 4'hF;
    in_m  = 8'd11;
    in_r  = 8'd1;
    in_r2 = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_m  = 8'd13;
    in_r  = 8'd9;
    in_r2 = 8'd3;
    check("poke_busy", busy, 1);
    finish_run("poke", base, 8);
    spur = 1'b0;

    // reset during the 4th WAIT, then a clean run
    base = n_starts;
    kick(8'd2, 4'd5, 3, 1'b0);
    guard = 0;
    while ((n_starts - base) < 4 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("rst_reach_op4", guard < 2000, 1);
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    void'(exp_q.pop_back());
    exp_op_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    base = n_starts;
    kick(8'd2, 4'd5, 3, 1'b0);
    finish_run("after_reset", base, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
